reduction_arbiter: RTL and testbench

- Shares one `windowed_reduction60bit` instance among NUM_REQ producers, e.g. NTT butterfly multipliers and the coefficient-wise multiplier.
- Producers offer 60-bit products with a modulus select (S/L) and a tag.
- The arbiter grants one request per cycle in round-robin order and drives the reducer.
- It tracks each in-flight operation through the reducer's fixed latency, then returns the 30-bit residue with requester ID and tag through a credit-protected output FIFO.

---
 rtl/reduction_arbiter.sv | 163 ++++++++++++++++
 tb/tb_reduction_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_arbiter.sv
// Round-robin front end that shares one windowed_reduction60bit among NUM_REQ producers.
// Define RED_ARB_PERF_EN to add saturating issue / credit-stall / backpressure counters.
module reduction_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int RED_LAT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CRED_W    = $clog2(FIFO_DEPTH + RED_LAT) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*60-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]       req_sel_i,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [59:0]              red_in_o,
    output logic                     red_modulus_sel_o,
    input  logic [29:0]              red_out_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [29:0]              res_data_o,
    output logic [ID_W-1:0]          res_id_o,
    output logic [TAG_W-1:0]         res_tag_o
`ifdef RED_ARB_PERF_EN
    ,
    output logic [31:0]              perf_issue_cnt_o,
    output logic [31:0]              perf_credit_stall_cnt_o,
    output logic [31:0]              perf_backpressure_cnt_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(FIFO_DEPTH);
    localparam logic [AW:0]       FULL_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_REQ - 1);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } meta_t;

    typedef struct packed {
        logic [29:0] data;
        meta_t       meta;
    } res_t;

    logic [NUM_REQ-1:0][59:0]      data_a;
    logic [NUM_REQ-1:0][TAG_W-1:0] tag_a;
    assign data_a = req_data_i;
    assign tag_a  = req_tag_i;

    logic [ID_W-1:0]   ptr_q, ptr_d, gnt_idx;
    logic              found, credit_ok, grant;
    logic [CRED_W-1:0] credits_used;
    meta_t             meta_in;
    logic [RED_LAT:0]  vld_pipe_q;
    meta_t [RED_LAT:0] meta_pipe_q;
    res_t              mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              push, pop;

    // Every issued op owns a FIFO slot from grant until pop, so the reducer never needs to stall.
    always_comb begin
        credits_used = CRED_W'(cnt_q);
        for (int s = 0; s <= RED_LAT; s++)
            credits_used = credits_used + CRED_W'(vld_pipe_q[s]);
    end

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid_i[j]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(j);
            end
        end
    end

    assign credit_ok   = (credits_used < DEPTH_C);
    assign grant       = found & credit_ok & ~rst;
    assign req_ready_o = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign ptr_d       = grant ? ((gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1) : ptr_q;
    assign meta_in     = '{id: gnt_idx, tag: tag_a[gnt_idx]};

    // Stage 0 sits beside red_in; stage RED_LAT lines up with red_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q             <= '0;
            red_in_o          <= '0;
            red_modulus_sel_o <= 1'b0;
            vld_pipe_q        <= '0;
            meta_pipe_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            vld_pipe_q  <= {vld_pipe_q[RED_LAT-1:0], grant};
            meta_pipe_q <= {meta_pipe_q[RED_LAT-1:0], meta_in};
            if (grant) begin
                red_in_o          <= data_a[gnt_idx];
                red_modulus_sel_o <= req_sel_i[gnt_idx];
            end
        end
    end

    assign push        = vld_pipe_q[RED_LAT];
    assign res_valid_o = (cnt_q != '0);
    assign pop         = res_valid_o & res_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{data: red_out_i, meta: meta_pipe_q[RED_LAT]};
    end

    assign {res_data_o, res_id_o, res_tag_o} = mem_q[rd_q];

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && cnt_q == FULL_C));
`endif

`ifdef RED_ARB_PERF_EN
    logic [31:0] issue_q, stall_q, bp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= '0;
            stall_q <= '0;
            bp_q    <= '0;
        end else begin
            if (grant && issue_q != '1)                      issue_q <= issue_q + 1'b1;
            if ((|req_valid_i) && !credit_ok && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (res_valid_o && !res_ready_i && bp_q != '1)   bp_q    <= bp_q + 1'b1;
        end
    end

    assign perf_issue_cnt_o        = issue_q;
    assign perf_credit_stall_cnt_o = stall_q;
    assign perf_backpressure_cnt_o = bp_q;
`endif

endmodule

// File: tb/tb_reduction_arbiter.sv
// Bench for reduction_arbiter: behavioural 3-cycle modular reducer plus an in-order result scoreboard.
module tb_reduction_arbiter;
    localparam int NR  = 2;
    localparam int LAT = 3;
    localparam int TW  = 4;
    localparam logic [63:0] MS = 64'd1068564481;
    localparam logic [63:0] ML = 64'd1068433409;

    typedef struct {
        logic [29:0]   d;
        int            id;
        logic [TW-1:0] tag;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR-1:0]         req_valid, req_sel, req_ready;
    logic [NR-1:0][59:0]   d_a;
    logic [NR-1:0][TW-1:0] tag_a;
    logic [59:0]           red_in;
    logic                  red_sel;
    logic [29:0]           red_out;
    logic                  res_valid, res_ready;
    logic [29:0]           res_data;
    logic [0:0]            res_id;
    logic [TW-1:0]         res_tag;

    always #5 clk = ~clk;

    reduction_arbiter #(.NUM_REQ(NR), .RED_LAT(LAT), .FIFO_DEPTH(4), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_data_i(d_a), .req_sel_i(req_sel), .req_tag_i(tag_a),
        .req_ready_o(req_ready),
        .red_in_o(red_in), .red_modulus_sel_o(red_sel), .red_out_i(red_out),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_id_o(res_id), .res_tag_o(res_tag)
    );

    function automatic logic [29:0] ref_mod(input logic [59:0] x, input logic s);
        logic [63:0] m;
        m = s ? ML : MS;
        return 30'({4'b0, x} % m);
    endfunction

    logic [29:0] m_q [LAT];
    always @(posedge clk) begin
        m_q[0] <= ref_mod(red_in, red_sel);
        for (int k = 1; k < LAT; k++) m_q[k] <= m_q[k-1];
    end
    assign red_out = m_q[LAT-1];

    int          total = 0, bad = 0, gnt_cnt = 0, res_cnt = 0, stop_at = 0, rr_exp = 0;
    bit          auto_en = 0, rr_chk = 0, rr_tog = 0, rr_have = 0;
    logic [NR-1:0] acc, rdy_neg;
    logic        rv_neg;
    logic [29:0] rd_neg;
    logic [0:0]  id_neg;
    exp_t        sb[$];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, obs, expv);
        end
    endtask

    task automatic new_req(input int i);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        d_a[i]       = r[59:0];
        req_sel[i]   = r[62];
        tag_a[i]     = TW'($urandom_range(0, 15));
        req_valid[i] = 1'b1;
    endtask

    // Observe on the falling edge, then drive just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        rv_neg  = res_valid;
        rd_neg  = res_data;
        id_neg  = res_id;
        rdy_neg = req_ready;
        if (!rst) begin
            if (!$onehot0(req_ready)) chk("onehot", 64'(req_ready), 64'd0);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{d: ref_mod(d_a[i], req_sel[i]), id: i, tag: tag_a[i]});
                    acc[i] = 1'b1;
                    gnt_cnt++;
                    if (rr_chk) begin
                        if (rr_have) chk("rr_order", i, rr_exp);
                        rr_exp  = (i + 1) % NR;
                        rr_have = 1'b1;
                    end
                    if (stop_at != 0 && gnt_cnt == stop_at) begin
                        auto_en = 1'b0;
                        stop_at = 0;
                    end
                end
            end
            if (res_valid && res_ready) begin
                res_cnt++;
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("res_data", res_data, e.d);
                    chk("res_id", res_id, e.id);
                    chk("res_tag", res_tag, e.tag);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                acc[i] = 1'b0;
                if (auto_en) new_req(i);
                else req_valid[i] = 1'b0;
            end
        end
        if (rr_tog) res_ready = ~res_ready;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != '0 || sb.size() != 0 || res_valid) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1, 0);
    endtask

    task automatic single(input int i, input logic [59:0] d, input logic s, input logic [TW-1:0] t,
                          input logic [29:0] exp_d, input string nm);
        int edges, g0;
        g0 = gnt_cnt;
        d_a[i] = d; req_sel[i] = s; tag_a[i] = t; req_valid[i] = 1'b1; res_ready = 1'b1;
        tick();
        chk({nm, "_gnt"}, gnt_cnt - g0, 1);
        edges = 0;
        while (edges < 20) begin
            tick();
            if (rv_neg) break;
            edges++;
        end
        chk({nm, "_lat"}, edges, 4);
        chk({nm, "_data"}, rd_neg, exp_d);
        chk({nm, "_id"}, id_neg, i);
    endtask

    initial begin
        int g0, r0, n;
        logic seen;
        rst = 1'b1; req_valid = '1; req_sel = '0; d_a = '0; tag_a = '0; res_ready = 1'b0; acc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_red_in", red_in, 0);
        chk("rst_red_sel", red_sel, 0);
        @(posedge clk); #1;
        req_valid = '0; rst = 1'b0;
        tick(); tick();

        single(0, 60'(5 * MS + 7), 1'b0, 4'd3, 30'd7, "single");
        drain();
        single(1, 60'(3 * ML - 1), 1'b1, 4'd9, 30'(ML - 1), "lmod");
        drain();

        rr_chk = 1; rr_have = 0; auto_en = 1; res_ready = 1'b1;
        new_req(0); new_req(1);
        g0 = gnt_cnt; r0 = res_cnt; n = 0;
        while (gnt_cnt - g0 < 12 && n < 200) begin tick(); n++; end
        auto_en = 0;
        drain();
        rr_chk = 0;
        chk("rr_count", res_cnt - r0, gnt_cnt - g0);

        res_ready = 1'b0; auto_en = 1;
        new_req(0); new_req(1);
        g0 = gnt_cnt;
        repeat (20) tick();
        chk("stall_grants", gnt_cnt - g0, 4);
        chk("stall_ready", rdy_neg, 0);
        chk("stall_res_valid", rv_neg, 1);
        chk("stall_head", rd_neg, sb[0].d);
        res_ready = 1'b1;
        repeat (30) tick();
        chk("stall_resume", (gnt_cnt - g0) > 8, 1);
        auto_en = 0;
        drain();

        res_ready = 1'b0; g0 = gnt_cnt; auto_en = 1; stop_at = gnt_cnt + 3;
        new_req(0);
        n = 0;
        while (auto_en && n < 50) begin tick(); n++; end
        chk("pre_rst_grants", gnt_cnt - g0, 3);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_async_clr", res_valid, 0);
        sb.delete(); acc = '0; req_valid = '0;
        tick(); tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin tick(); seen = seen | rv_neg; end
        chk("rst_quiet", seen, 0);
        r0 = res_cnt;
        single(1, 60'(1000 * MS + 12345), 1'b0, 4'd6, 30'd12345, "post_rst");
        drain();
        chk("post_rst_res", res_cnt - r0, 1);

        rr_tog = 1; auto_en = 1; g0 = gnt_cnt; r0 = res_cnt; stop_at = gnt_cnt + 100;
        new_req(0); new_req(1);
        n = 0;
        while (auto_en && n < 3000) begin tick(); n++; end
        if (auto_en) chk("rand_timeout", 1, 0);
        auto_en = 0;
        drain();
        rr_tog = 0;
        chk("rand_count", res_cnt - r0, gnt_cnt - g0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
